// File: rtl/wb_spi_burst_master.sv
// wb_spi_burst_master
// Wishbone classic master engine behind the SPI slave frame layer. It takes one
// command (read/write, start word address, beat count) and runs it as a string
// of single-beat Wishbone cycles with word-address auto-increment. Write data
// streams in and read data streams out through valid/ready handshakes.
// After a bus error the rest of the burst is skipped but the data streams keep
// their full length, so the SPI frame stays intact.
// Optional build macro: WB_SPI_BURST_TIMEOUT_EN adds a per-beat ack/err timeout.
//
// Handshake semantics (cmd, wdat, rdat): a transfer happens on a rising clk edge
// where valid and ready are both high; a producer holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module wb_spi_burst_master #(
    parameter int ADR_W   = 24,
    parameter int DAT_W   = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_vld,
    output logic                                  cmd_rdy,
    input  logic                                  cmd_we,
    input  logic [ADR_W-1:0]                      cmd_adr,
    input  logic [LEN_W-1:0]                      cmd_len,
    input  logic                                  wdat_vld,
    output logic                                  wdat_rdy,
    input  logic [DAT_W-1:0]                      wdat,
    output logic                                  rdat_vld,
    input  logic                                  rdat_rdy,
    output logic [DAT_W-1:0]                      rdat,
    output logic                                  o_wb_cyc,
    output logic                                  o_wb_stb,
    output logic                                  o_wb_we,
    output logic [ADR_W+$clog2(DAT_W/8)-1:0]      o_wb_adr,
    output logic [DAT_W-1:0]                      o_wb_dat,
    output logic [DAT_W/8-1:0]                    o_wb_sel,
    input  logic                                  i_wb_ack,
    input  logic                                  i_wb_err,
    input  logic [DAT_W-1:0]                      i_wb_dat,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int BSEL  = $clog2(DAT_W/8);
    localparam int WB_AW = ADR_W + BSEL;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;

    // Elaboration-time parameter sanity checks.
    generate
        if (!(DAT_W == 8 || DAT_W == 16 || DAT_W == 32 || DAT_W == 64)) begin : g_bad_dat_w
            $error("wb_spi_burst_master: DAT_W must be 8, 16, 32 or 64");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("wb_spi_burst_master: TIMEOUT must be in 1..65535");
        end
    endgenerate

    logic [1:0]       state;
    logic             we_q;       // direction of the running burst
    logic             skip_q;     // set after error/timeout: no more bus cycles
    logic [ADR_W-1:0] adr_q;      // word address of the current beat
    logic [LEN_W-1:0] left_q;     // beats remaining after the current one

    logic fetch_go;   // FETCH may finish: data in hand (write) or slot free (read)
    logic resp;       // current bus cycle ends this clock
    logic bad;        // the ending cycle is a failure (error or timeout)
    logic beat_end;   // current beat completes this clock
    logic to_hit;     // per-beat timeout expired

`ifdef WB_SPI_BURST_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = (state == REQ) && (to_cnt == 16'(TIMEOUT - 1));

    // Count REQ cycles without a response; REQ is always entered from FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == FETCH) begin
            to_cnt <= '0;
        end else if (state == REQ && !i_wb_ack && !i_wb_err) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign o_wb_sel = '1;
    assign wdat_rdy = (state == FETCH) && we_q;

    assign fetch_go = (state == FETCH) && (we_q ? wdat_vld : (!rdat_vld || rdat_rdy));
    assign resp     = (state == REQ) && (i_wb_ack || i_wb_err || to_hit);
    assign bad      = i_wb_err || (to_hit && !i_wb_ack);
    assign beat_end = resp || (fetch_go && skip_q);

    // Main sequencer: command accept, beat fetch, bus request and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            skip_q   <= 1'b0;
            adr_q    <= '0;
            left_q   <= '0;
            cmd_rdy  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdat     <= '0;
            rdat_vld <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
        end else begin
            done <= 1'b0;

            // The read slot empties on a transfer; a new beat below may refill it.
            if (rdat_vld && rdat_rdy) begin
                rdat_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy) begin
                        we_q    <= cmd_we;
                        adr_q   <= cmd_adr;
                        left_q  <= cmd_len;
                        skip_q  <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        cmd_rdy <= 1'b0;
                        state   <= FETCH;
                    end else begin
                        cmd_rdy <= 1'b1;
                    end
                end

                FETCH: begin
                    if (fetch_go) begin
                        if (!skip_q) begin
                            if (we_q) begin
                                o_wb_dat <= wdat;
                            end
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_we  <= we_q;
                            o_wb_adr <= WB_AW'(adr_q) << BSEL;
                            state    <= REQ;
                        end else if (!we_q) begin
                            // Skipped read beat: pad the stream with all ones.
                            rdat     <= '1;
                            rdat_vld <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (resp) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        if (bad) begin
                            err    <= 1'b1;
                            skip_q <= 1'b1;
                            if (!we_q) begin
                                rdat     <= '1;
                                rdat_vld <= 1'b1;
                            end
                        end else if (!we_q) begin
                            rdat     <= i_wb_dat;
                            rdat_vld <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Beat bookkeeping shared by real and skipped beats.
            if (beat_end) begin
                if (left_q == '0) begin
                    state   <= IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    cmd_rdy <= 1'b1;
                    skip_q  <= 1'b0;
                end else begin
                    left_q <= left_q - 1'b1;
                    adr_q  <= adr_q + 1'b1;
                    state  <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_spi_burst_master.sv
// Testbench for wb_spi_burst_master: randomized commands, a reference model that
// turns each command into expected bus cycles and read data, a Wishbone slave
// process that checks every bus cycle, and a read-stream monitor.
module tb_wb_spi_burst_master;

    localparam int ADR_W = 24;
    localparam int DAT_W = 32;
    localparam int LEN_W = 4;
    localparam int TO    = 8;
    localparam int HOLD_CAP = 40;

    localparam logic [1:0] K_ACK  = 2'd0;
    localparam logic [1:0] K_ERR  = 2'd1;
    localparam logic [1:0] K_NONE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    // ---------------- DUT ----------------
    logic              cmd_vld, cmd_rdy, cmd_we;
    logic [ADR_W-1:0]  cmd_adr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdat_vld, wdat_rdy;
    logic [DAT_W-1:0]  wdat;
    logic              rdat_vld, rdat_rdy;
    logic [DAT_W-1:0]  rdat;
    logic              o_wb_cyc, o_wb_stb, o_wb_we;
    logic [ADR_W+1:0]  o_wb_adr;
    logic [DAT_W-1:0]  o_wb_dat;
    logic [3:0]        o_wb_sel;
    logic              i_wb_ack, i_wb_err;
    logic [DAT_W-1:0]  i_wb_dat;
    logic              busy, done, err;

    wb_spi_burst_master #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .LEN_W(LEN_W), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_vld(wdat_vld), .wdat_rdy(wdat_rdy), .wdat(wdat),
        .rdat_vld(rdat_vld), .rdat_rdy(rdat_rdy), .rdat(rdat),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;

    logic [58:0] exp_bus_q[$];   // {we, byte address, write data}
    logic [9:0]  resp_q[$];      // {kind, wait cycles}
    logic [31:0] exp_rdat_q[$];

    logic [31:0] wd_tab[16];
    int  done_cnt    = 0;
    int  req_cnt     = 0;
    int  first_req_n = -1;
    int  rvld_first  = -1;
    bit  hung        = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [25:0] ba);
        return {6'h15, ba} ^ 32'h3C3C_0000;
    endfunction

    // ---------------- Wishbone slave / bus monitor ----------------
    logic [58:0] s_e;
    logic [9:0]  s_r;
    logic [1:0]  s_kind;
    int          s_wait;
    int          s_hold;
    logic [25:0] s_adr;

    always begin
        @(negedge clk);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (rst_n && o_wb_cyc && o_wb_stb) begin
            req_cnt++;
            if (first_req_n < 0) first_req_n = cyc_n;
            check("wb_sel", o_wb_sel, 4'hF);
            if (!o_wb_we) check("slot_free", rdat_vld, 1'b0);
            s_kind = K_ACK;
            s_wait = 0;
            if (exp_bus_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL bus_unexpected: got cycle at adr %0h, expected none", o_wb_adr);
            end else begin
                s_e = exp_bus_q.pop_front();
                check("bus_we", o_wb_we, s_e[58]);
                check("bus_adr", o_wb_adr, s_e[57:32]);
                if (s_e[58]) check("bus_dat", o_wb_dat, s_e[31:0]);
                if (resp_q.size() > 0) begin
                    s_r    = resp_q.pop_front();
                    s_kind = s_r[9:8];
                    s_wait = int'(s_r[7:0]);
                end
            end
            s_adr = o_wb_adr;
            for (int k = 0; k < s_wait; k++) begin
                @(negedge clk);
                check("bus_hold", {o_wb_cyc, o_wb_stb, o_wb_adr}, {2'b11, s_adr});
            end
            if (s_kind == K_ACK) begin
                i_wb_ack = 1'b1;
                i_wb_dat = slave_data(o_wb_adr);
            end else if (s_kind == K_ERR) begin
                i_wb_err = 1'b1;
                i_wb_dat = $urandom;
            end else begin
                s_hold = 0;
                while (o_wb_cyc && s_hold < HOLD_CAP) begin
                    s_hold++;
                    @(negedge clk);
                end
`ifdef WB_SPI_BURST_TIMEOUT_EN
                if (rst_n) check("timeout_len", s_hold, TO);
`endif
                if (o_wb_cyc) begin
                    hung = 1'b1;
                    s_hold = 0;
                    while (o_wb_cyc && s_hold < 1000) begin
                        s_hold++;
                        @(negedge clk);
                    end
                end
            end
        end
    end

    // ---------------- read stream monitor ----------------
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rdat_vld && rvld_first < 0) rvld_first = cyc_n;
        rdat_rdy = ($urandom_range(0, 1) == 1);
        if (rdat_vld && rdat_rdy) begin
            if (exp_rdat_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rdat_unexpected: got %0h, expected no beat", rdat);
            end else begin
                check("rdat", rdat, exp_rdat_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input bit we, input logic [23:0] adr, input int len, output int acc_n);
        int n;
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd_we  = we;
        cmd_adr = adr;
        cmd_len = 4'(len);
        n = 0;
        while (!cmd_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accepted", cmd_rdy, 1'b1);
        acc_n = cyc_n;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_adr = 24'($urandom);
        check("busy_after_accept", busy, 1'b1);
        check("err_clear_on_accept", err, 1'b0);
        check("cmd_rdy_while_busy", cmd_rdy, 1'b0);
    endtask

    task automatic apply_reset(input bit chk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_cyc", o_wb_cyc, 1'b0);
            check("rst_stb", o_wb_stb, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_rdat_vld", rdat_vld, 1'b0);
        end
        exp_bus_q.delete();
        resp_q.delete();
        exp_rdat_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hung = 1'b0;
    endtask

    // Model: every beat is a bus cycle until the first failure; later beats are
    // skipped, reads deliver all ones, writes still take their data.
    task automatic run_cmd(input bit we, input logic [23:0] adr, input int len,
                           input int err_beat, input int none_beat,
                           input int fixed_wait, input bit chk_lat);
        bit          skip;
        bit          exp_err;
        logic [23:0] a;
        logic [25:0] ba;
        int          w, d0, acc_n, n, consumed;

        skip    = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a  = adr + 24'(i);
            ba = {a, 2'b00};
            if (skip) begin
                if (!we) exp_rdat_q.push_back(32'hFFFF_FFFF);
                continue;
            end
            exp_bus_q.push_back({we, ba, (we ? wd_tab[i] : 32'h0)});
            w = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
            if (i == err_beat) begin
                resp_q.push_back({K_ERR, 8'(w)});
                skip = 1'b1;
                exp_err = 1'b1;
                if (!we) exp_rdat_q.push_back(32'hFFFF_FFFF);
            end else if (i == none_beat) begin
                resp_q.push_back({K_NONE, 8'd0});
                skip = 1'b1;
                exp_err = 1'b1;
                if (!we) exp_rdat_q.push_back(32'hFFFF_FFFF);
            end else begin
                resp_q.push_back({K_ACK, 8'(w)});
                if (!we) exp_rdat_q.push_back(slave_data(ba));
            end
        end

        d0 = done_cnt;
        first_req_n = -1;
        rvld_first  = -1;
        issue_cmd(we, adr, len, acc_n);

        if (we) begin
            consumed = 0;
            for (int i = 0; i <= len; i++) begin
                wdat_vld = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                wdat_vld = 1'b1;
                wdat     = wd_tab[i];
                n = 0;
                while (!wdat_rdy && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (!wdat_rdy) break;
                @(negedge clk);
                consumed++;
            end
            wdat_vld = 1'b0;
            check("wdat_consumed", consumed, len + 1);
        end

        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", (done_cnt != d0), 1'b1);
        n = 0;
        while (exp_rdat_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rdat_drained", exp_rdat_q.size(), 0);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("err_flag", err, exp_err);
        check("busy_end", busy, 1'b0);
        check("bus_all_issued", exp_bus_q.size(), 0);
        if (chk_lat) begin
            check("lat_cyc", first_req_n - acc_n, 2);
            check("lat_rdat", rvld_first - acc_n, 3);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_wd();
        for (int i = 0; i < 16; i++) wd_tab[i] = $urandom;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int          acc_n, n, r0, len, eb;
        logic [23:0] adr;
        bit          we;

        rst_n    = 1'b1;
        cmd_vld  = 1'b0;
        cmd_we   = 1'b0;
        cmd_adr  = '0;
        cmd_len  = '0;
        wdat_vld = 1'b0;
        wdat     = '0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_wb_dat = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_cmd_rdy", cmd_rdy, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_cyc_stb", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
        check("reset_adr", o_wb_adr, 26'h0);
        check("reset_sel", o_wb_sel, 4'hF);
        check("reset_rdat_vld", rdat_vld, 1'b0);
        check("reset_wdat_rdy", wdat_rdy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write with two wait states
        fill_wd();
        wd_tab[0] = 32'hCAFE_F00D;
        run_cmd(1'b1, 24'h000010, 0, -1, -1, 2, 1'b0);

        // Single read with zero-wait ack: latency check
        run_cmd(1'b0, 24'h0000A0, 0, -1, -1, 0, 1'b1);

        // Read burst of four
        run_cmd(1'b0, 24'h000100, 3, -1, -1, -1, 1'b0);

        // Address wrap
        run_cmd(1'b0, 24'hFFFFFF, 1, -1, -1, -1, 1'b0);

        // Bus error on beat 1 of a write burst; next read clears err
        fill_wd();
        run_cmd(1'b1, 24'h000200, 3, 1, -1, -1, 1'b0);
        run_cmd(1'b0, 24'h000040, 1, -1, -1, -1, 1'b0);

        // Read error on first beat of a maximum burst
        run_cmd(1'b0, 24'h000500, 15, 0, -1, -1, 1'b0);

        // Maximum write burst
        fill_wd();
        run_cmd(1'b1, 24'h123456, 15, -1, -1, -1, 1'b0);

        // Slave never responds
`ifdef WB_SPI_BURST_TIMEOUT_EN
        run_cmd(1'b0, 24'h000300, 1, -1, 0, -1, 1'b0);
`else
        exp_bus_q.push_back({1'b0, 24'h000300, 2'b00, 32'h0});
        resp_q.push_back({K_NONE, 8'd0});
        hung = 1'b0;
        issue_cmd(1'b0, 24'h000300, 1, acc_n);
        n = 0;
        while (!hung && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("no_timeout_hang", hung, 1'b1);
        check("no_timeout_cyc_high", o_wb_cyc, 1'b1);
        apply_reset(1'b0);
`endif

        // Reset during REQ of beat 2 of 4
        exp_bus_q.push_back({1'b0, 24'h000600, 2'b00, 32'h0});
        resp_q.push_back({K_ACK, 8'd0});
        exp_rdat_q.push_back(slave_data({24'h000600, 2'b00}));
        exp_bus_q.push_back({1'b0, 24'h000601, 2'b00, 32'h0});
        resp_q.push_back({K_NONE, 8'd0});
        r0 = req_cnt;
        issue_cmd(1'b0, 24'h000600, 3, acc_n);
        n = 0;
        while (req_cnt < r0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_beat2", req_cnt - r0, 2);
        apply_reset(1'b1);
        fill_wd();
        run_cmd(1'b1, 24'h000700, 2, -1, -1, -1, 1'b0);

        // Randomized commands
        for (int t = 0; t < 24; t++) begin
            fill_wd();
            we  = ($urandom_range(0, 1) == 1);
            adr = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 + 24'($urandom_range(0, 15)))
                                              : 24'($urandom);
            len = $urandom_range(0, 15);
            eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            run_cmd(we, adr, len, eb, -1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
